purchase_credit_front: RTL and testbench
========================================

Name: purchase_credit_front

Overview:
- Upstream stage of the purchase manager: it accepts coins, keeps the running customer credit, and turns a user buy request into the `buy`/`product`/`credit` drive the purchase manager consumes.
- It monitors the purchase manager's `apple`/`banana`/`carrot`/`date`/`error` result lines and deducts the price on a successful vend.
- It also handles refund of the remaining credit.

Parameters:
- COIN0_VAL, 5, credit value of coin_type 2'b00
- COIN1_VAL, 10, credit value of coin_type 2'b01
- COIN2_VAL, 25, credit value of coin_type 2'b10
- COIN3_VAL, 50, credit value of coin_type 2'b11
- PRICE_APPLE, 75, price of product 2'b00
- PRICE_BANANA, 20, price of product 2'b01
- PRICE_CARROT, 30, price of product 2'b10
- PRICE_DATE, 40, price of product 2'b11
- TIMEOUT, 8, cycles to wait for a purchase result before declaring failure (>=2)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- coin_valid  input  1  one-cycle strobe: a coin was inserted
- coin_type  input  2  coin denomination, qualified by coin_valid
- buy_req  input  1  user buy button (level)
- product_sel  input  2  user product choice, sampled with buy_req
- refund_req  input  1  user refund button (level)
- apple, banana, carrot, date  input  1 each  vend result from the purchase manager
- error  input  1  purchase rejected by the purchase manager
- buy  output  1  purchase request to the purchase manager
- product  output  2  latched product code to the purchase manager
- credit  output  8  current credit, unsigned
- coin_reject  output  1  one-cycle pulse: coin returned, not credited
- refund_valid  output  1  one-cycle pulse: refund_amount is valid
- refund_amount  output  8  credit returned on refund
- vend_done  output  1  one-cycle pulse: vend succeeded and price deducted
- vend_fail  output  1  one-cycle pulse: error, mismatch or timeout

Behaviour:
- Reset: reset==0 at a clk rising edge clears all of the following.
  - Outputs: credit=0, buy=0, product=0, coin_reject=0, refund_valid=0, refund_amount=0, vend_done=0, vend_fail=0.
  - Internal: state=IDLE, timeout counter=0.
  - Reset has priority over every other input in every state. Reset during WAIT abandons the purchase and zeroes credit with no refund pulse.
- Registered outputs: every output is registered and changes only on a clk rising edge.
- State machine states: IDLE, WAIT, RELEASE.
- IDLE priority, highest first: refund_req > buy_req > coin.
  - refund_req=1:
    - refund_amount<=credit, refund_valid pulses 1 cycle, credit<=0.
    - A coin_valid in the same cycle is rejected (coin_reject pulse).
    - Refund with credit=0 still pulses refund_valid with amount 0.
  - buy_req=1 (no refund):
    - product<=product_sel, buy<=1, timeout counter<=0, go to WAIT.
    - A coin_valid in the same cycle is still credited (normal coin rules), so the credit seen in the first WAIT cycle includes it.
  - coin_valid=1 alone:
    - The sum is computed 9 bits wide, credit + coin value.
    - If sum<=255: credit<=sum.
    - Otherwise: credit unchanged and coin_reject pulses. Never wrap or saturate.
- WAIT:
  - buy stays 1; product and credit are held stable.
  - Every coin_valid is rejected (coin_reject pulse). refund_req and buy_req are ignored.
  - Result checked each cycle:
    - Exactly one vend line high and it matches the latched product (apple=00, banana=01, carrot=10, date=11), and credit>=price:
      - credit<=credit-price, vend_done pulses.
    - error=1, more than one vend line high, a non-matching vend line, or credit<price: credit unchanged, vend_fail pulses.
    - Any result, accepted or failed: buy<=0, go to RELEASE.
  - Timeout: after TIMEOUT WAIT cycles with no vend/error line high, vend_fail pulses, buy<=0, go to RELEASE.
- RELEASE:
  - buy=0. Coins are credited under the IDLE coin rules.
  - Go to IDLE when buy_req==0. This prevents a held button re-buying.
  - refund_req is ignored until IDLE.
- Pulse width: all pulse outputs are exactly 1 cycle wide and low otherwise.

Test Plan:
- Reset, then coin_type 11,11 (one strobe each) -> credit 50 then 100; refund_req -> refund_valid=1 with refund_amount=100, credit=0 next cycle.
- Credit 100, buy_req with product_sel=00, purchase manager answers apple=1 two cycles later -> buy=1 for 3 cycles, vend_done pulse, credit=25, buy=0; state stays RELEASE until buy_req drops.
- Credit 20, buy product 11, purchase manager answers error=1 -> vend_fail pulse, credit stays 20, buy drops.
- Credit 250, coin 00 -> credit 255; coin 00 again -> coin_reject pulse, credit stays 255; any coin inserted during WAIT -> coin_reject.
- Buy product 01 with no result for TIMEOUT=8 cycles -> vend_fail at cycle 8, buy=0, credit unchanged; returning banana=1 while product=10 -> vend_fail.
- Drive reset=0 mid-WAIT with credit 60 -> next edge: buy=0, credit=0, state IDLE, no refund_valid.

Source files
------------

// File: rtl/purchase_credit_front_if.sv
// Signal bundle between the user/purchase-manager side and purchase_credit_front.
// The front end attaches through the slave modport, and the driving side attaches through the master modport.
interface purchase_credit_front_if;
   logic       coin_valid;
   logic [1:0] coin_type;
   logic       buy_req;
   logic [1:0] product_sel;
   logic       refund_req;
   logic       apple;
   logic       banana;
   logic       carrot;
   logic       date;
   logic       error;
   logic       buy;
   logic [1:0] product;
   logic [7:0] credit;
   logic       coin_reject;
   logic       refund_valid;
   logic [7:0] refund_amount;
   logic       vend_done;
   logic       vend_fail;

   modport master (
      output coin_valid, coin_type, buy_req, product_sel, refund_req,
             apple, banana, carrot, date, error,
      input  buy, product, credit, coin_reject, refund_valid, refund_amount,
             vend_done, vend_fail
   );

   modport slave (
      input  coin_valid, coin_type, buy_req, product_sel, refund_req,
             apple, banana, carrot, date, error,
      output buy, product, credit, coin_reject, refund_valid, refund_amount,
             vend_done, vend_fail
   );
endinterface

// File: rtl/purchase_credit_front.sv
// Coin/credit front end of the purchase manager: accumulates credit, issues buy requests,
// checks the vend result lines and deducts the price, and handles refunds.
module purchase_credit_front #(
   parameter int COIN0_VAL    = 5,
   parameter int COIN1_VAL    = 10,
   parameter int COIN2_VAL    = 25,
   parameter int COIN3_VAL    = 50,
   parameter int PRICE_APPLE  = 75,
   parameter int PRICE_BANANA = 20,
   parameter int PRICE_CARROT = 30,
   parameter int PRICE_DATE   = 40,
   parameter int TIMEOUT      = 8
) (
   input logic                    clk,
   input logic                    reset,
   purchase_credit_front_if.slave bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RELEASE
   } state_t;

   state_t     r_state;
   logic [CNT_W-1:0] r_timer;
   logic       r_buy;
   logic [1:0] r_product;
   logic [7:0] r_credit;
   logic       r_coin_reject;
   logic       r_refund_valid;
   logic [7:0] r_refund_amount;
   logic       r_vend_done;
   logic       r_vend_fail;

   logic [7:0] w_coin_val;
   logic [8:0] w_sum;
   logic       w_coin_fits;
   logic [7:0] w_price;
   logic [3:0] w_vend;
   logic       w_result;
   logic       w_good;

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      w_coin_val = 8'(COIN0_VAL);
      unique case (bus.coin_type)
         2'b00: w_coin_val = 8'(COIN0_VAL);
         2'b01: w_coin_val = 8'(COIN1_VAL);
         2'b10: w_coin_val = 8'(COIN2_VAL);
         2'b11: w_coin_val = 8'(COIN3_VAL);
      endcase
      w_price = 8'(PRICE_APPLE);
      unique case (r_product)
         2'b00: w_price = 8'(PRICE_APPLE);
         2'b01: w_price = 8'(PRICE_BANANA);
         2'b10: w_price = 8'(PRICE_CARROT);
         2'b11: w_price = 8'(PRICE_DATE);
      endcase
      // Sum is one bit wider so an overflowing coin is rejected rather than wrapped.
      w_sum       = {1'b0, r_credit} + {1'b0, w_coin_val};
      w_coin_fits = ~w_sum[8];
      w_vend      = {bus.date, bus.carrot, bus.banana, bus.apple};
      w_result    = (|w_vend) | bus.error;
      w_good      = !bus.error && (w_vend == (4'b0001 << r_product)) && (r_credit >= w_price);
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state         <= S_IDLE;
         r_timer         <= '0;
         r_buy           <= 1'b0;
         r_product       <= 2'b00;
         r_credit        <= 8'd0;
         r_coin_reject   <= 1'b0;
         r_refund_valid  <= 1'b0;
         r_refund_amount <= 8'd0;
         r_vend_done     <= 1'b0;
         r_vend_fail     <= 1'b0;
      end else begin
         r_coin_reject  <= 1'b0;
         r_refund_valid <= 1'b0;
         r_vend_done    <= 1'b0;
         r_vend_fail    <= 1'b0;

         unique case (r_state)
            S_IDLE: begin
               if (bus.refund_req) begin
                  r_refund_amount <= r_credit;
                  r_refund_valid  <= 1'b1;
                  r_credit        <= 8'd0;
                  r_coin_reject   <= bus.coin_valid;
               end else begin
                  if (bus.buy_req) begin
                     r_product <= bus.product_sel;
                     r_buy     <= 1'b1;
                     r_timer   <= '0;
                     r_state   <= S_WAIT;
                  end
                  if (bus.coin_valid) begin
                     if (w_coin_fits) r_credit <= w_sum[7:0];
                     else             r_coin_reject <= 1'b1;
                  end
               end
            end

            S_WAIT: begin
               r_coin_reject <= bus.coin_valid;
               if (w_result) begin
                  if (w_good) begin
                     r_credit    <= r_credit - w_price;
                     r_vend_done <= 1'b1;
                  end else begin
                     r_vend_fail <= 1'b1;
                  end
                  r_buy   <= 1'b0;
                  r_state <= S_RELEASE;
               end else if (r_timer == CNT_W'(TIMEOUT - 1)) begin
                  r_vend_fail <= 1'b1;
                  r_buy       <= 1'b0;
                  r_state     <= S_RELEASE;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end

            S_RELEASE: begin
               // Wait for the button to drop so a held buy_req cannot start a second purchase.
               if (bus.coin_valid) begin
                  if (w_coin_fits) r_credit <= w_sum[7:0];
                  else             r_coin_reject <= 1'b1;
               end
               if (!bus.buy_req) r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.buy           = r_buy;
   assign bus.product       = r_product;
   assign bus.credit        = r_credit;
   assign bus.coin_reject   = r_coin_reject;
   assign bus.refund_valid  = r_refund_valid;
   assign bus.refund_amount = r_refund_amount;
   assign bus.vend_done     = r_vend_done;
   assign bus.vend_fail     = r_vend_fail;

endmodule

// File: tb/tb_purchase_credit_front.sv
// Directed bench for purchase_credit_front: coins, refunds, vends, errors, mismatches,
// timeout and reset during a pending purchase, with hand-computed expectations.
module tb_purchase_credit_front;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   purchase_credit_front_if bus ();

   purchase_credit_front #(.TIMEOUT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic coin(input logic [1:0] t);
      bus.coin_valid = 1'b1;
      bus.coin_type  = t;
      tick();
      bus.coin_valid = 1'b0;
   endtask

   task automatic refund();
      bus.refund_req = 1'b1;
      tick();
      bus.refund_req = 1'b0;
   endtask

   initial begin
      reset           = 1'b0;
      bus.coin_valid  = 1'b0;
      bus.coin_type   = 2'b00;
      bus.buy_req     = 1'b0;
      bus.product_sel = 2'b00;
      bus.refund_req  = 1'b0;
      bus.apple       = 1'b0;
      bus.banana      = 1'b0;
      bus.carrot      = 1'b0;
      bus.date        = 1'b0;
      bus.error       = 1'b0;
      tick();
      tick();
      check("rst_credit", 9'(bus.credit), 9'd0);
      check("rst_buy", 9'(bus.buy), 9'd0);
      check("rst_product", 9'(bus.product), 9'd0);
      check("rst_coin_reject", 9'(bus.coin_reject), 9'd0);
      check("rst_refund_valid", 9'(bus.refund_valid), 9'd0);
      check("rst_refund_amount", 9'(bus.refund_amount), 9'd0);
      check("rst_vend_done", 9'(bus.vend_done), 9'd0);
      check("rst_vend_fail", 9'(bus.vend_fail), 9'd0);
      reset = 1'b1;

      // Two 50 coins, then refund
      coin(2'b11);
      check("coin50_credit", 9'(bus.credit), 9'd50);
      coin(2'b11);
      check("coin100_credit", 9'(bus.credit), 9'd100);
      refund();
      check("refund_valid", 9'(bus.refund_valid), 9'd1);
      check("refund_amount", 9'(bus.refund_amount), 9'd100);
      check("refund_credit", 9'(bus.credit), 9'd0);
      tick();
      check("refund_pulse_low", 9'(bus.refund_valid), 9'd0);

      // Buy apple with credit 100, result in third WAIT cycle
      coin(2'b11);
      coin(2'b11);
      bus.buy_req = 1'b1;
      bus.product_sel = 2'b00;
      tick();
      check("apple_buy1", 9'(bus.buy), 9'd1);
      check("apple_product", 9'(bus.product), 9'd0);
      check("apple_credit_wait", 9'(bus.credit), 9'd100);
      tick();
      check("apple_buy2", 9'(bus.buy), 9'd1);
      tick();
      check("apple_buy3", 9'(bus.buy), 9'd1);
      bus.apple = 1'b1;
      tick();
      bus.apple = 1'b0;
      check("apple_buy_drop", 9'(bus.buy), 9'd0);
      check("apple_vend_done", 9'(bus.vend_done), 9'd1);
      check("apple_credit", 9'(bus.credit), 9'd25);
      tick();
      check("apple_done_low", 9'(bus.vend_done), 9'd0);
      check("release_no_rebuy", 9'(bus.buy), 9'd0);
      coin(2'b00);
      check("release_coin", 9'(bus.credit), 9'd30);
      check("release_still_no_buy", 9'(bus.buy), 9'd0);
      bus.buy_req = 1'b0;
      tick();

      // Error result with credit 20
      refund();
      check("refund30_amount", 9'(bus.refund_amount), 9'd30);
      coin(2'b01);
      coin(2'b01);
      check("credit20", 9'(bus.credit), 9'd20);
      bus.buy_req = 1'b1;
      bus.product_sel = 2'b11;
      tick();
      bus.buy_req = 1'b0;
      check("date_buy", 9'(bus.buy), 9'd1);
      check("date_product", 9'(bus.product), 9'd3);
      bus.error = 1'b1;
      tick();
      bus.error = 1'b0;
      check("error_vend_fail", 9'(bus.vend_fail), 9'd1);
      check("error_credit", 9'(bus.credit), 9'd20);
      check("error_buy_drop", 9'(bus.buy), 9'd0);
      tick();
      check("error_fail_low", 9'(bus.vend_fail), 9'd0);

      // Overflow boundary: 250 + 5 = 255, then reject
      refund();
      for (int i = 0; i < 5; i++) coin(2'b11);
      check("credit250", 9'(bus.credit), 9'd250);
      coin(2'b00);
      check("credit255", 9'(bus.credit), 9'd255);
      check("no_reject_255", 9'(bus.coin_reject), 9'd0);
      coin(2'b00);
      check("overflow_reject", 9'(bus.coin_reject), 9'd1);
      check("overflow_credit", 9'(bus.credit), 9'd255);
      tick();
      check("reject_pulse_low", 9'(bus.coin_reject), 9'd0);

      // Timeout on banana, with a coin rejected during WAIT
      bus.buy_req = 1'b1;
      bus.product_sel = 2'b01;
      tick();
      bus.buy_req = 1'b0;
      check("to_buy", 9'(bus.buy), 9'd1);
      coin(2'b01);
      check("wait_coin_reject", 9'(bus.coin_reject), 9'd1);
      check("wait_coin_credit", 9'(bus.credit), 9'd255);
      for (int i = 0; i < 6; i++) tick();
      check("to_buy_before", 9'(bus.buy), 9'd1);
      check("to_fail_before", 9'(bus.vend_fail), 9'd0);
      tick();
      check("to_vend_fail", 9'(bus.vend_fail), 9'd1);
      check("to_buy_drop", 9'(bus.buy), 9'd0);
      check("to_credit", 9'(bus.credit), 9'd255);
      tick();

      // Buy carrot with a coin in the same cycle, then answer banana (mismatch)
      refund();
      check("refund255_amount", 9'(bus.refund_amount), 9'd255);
      bus.buy_req = 1'b1;
      bus.product_sel = 2'b10;
      bus.coin_valid = 1'b1;
      bus.coin_type = 2'b11;
      tick();
      bus.coin_valid = 1'b0;
      bus.buy_req = 1'b0;
      check("buycoin_credit", 9'(bus.credit), 9'd50);
      check("buycoin_product", 9'(bus.product), 9'd2);
      bus.banana = 1'b1;
      tick();
      bus.banana = 1'b0;
      check("mismatch_fail", 9'(bus.vend_fail), 9'd1);
      check("mismatch_no_done", 9'(bus.vend_done), 9'd0);
      check("mismatch_credit", 9'(bus.credit), 9'd50);
      tick();

      // Insufficient credit: apple (75) with credit 50
      bus.buy_req = 1'b1;
      bus.product_sel = 2'b00;
      tick();
      bus.buy_req = 1'b0;
      bus.apple = 1'b1;
      tick();
      bus.apple = 1'b0;
      check("short_fail", 9'(bus.vend_fail), 9'd1);
      check("short_credit", 9'(bus.credit), 9'd50);
      tick();

      // Two vend lines at once: fail
      bus.buy_req = 1'b1;
      bus.product_sel = 2'b10;
      tick();
      bus.buy_req = 1'b0;
      bus.carrot = 1'b1;
      bus.date = 1'b1;
      tick();
      bus.carrot = 1'b0;
      bus.date = 1'b0;
      check("multi_fail", 9'(bus.vend_fail), 9'd1);
      check("multi_credit", 9'(bus.credit), 9'd50);
      tick();

      // Carrot 30 from 50 -> 20, then banana 20 exactly -> 0
      bus.buy_req = 1'b1;
      bus.product_sel = 2'b10;
      tick();
      bus.buy_req = 1'b0;
      bus.carrot = 1'b1;
      tick();
      bus.carrot = 1'b0;
      check("carrot_done", 9'(bus.vend_done), 9'd1);
      check("carrot_credit", 9'(bus.credit), 9'd20);
      tick();
      bus.buy_req = 1'b1;
      bus.product_sel = 2'b01;
      tick();
      bus.buy_req = 1'b0;
      bus.banana = 1'b1;
      tick();
      bus.banana = 1'b0;
      check("exact_done", 9'(bus.vend_done), 9'd1);
      check("exact_credit", 9'(bus.credit), 9'd0);
      tick();

      // Reset during WAIT with credit 60
      coin(2'b11);
      coin(2'b01);
      check("credit60", 9'(bus.credit), 9'd60);
      bus.buy_req = 1'b1;
      bus.product_sel = 2'b00;
      tick();
      bus.buy_req = 1'b0;
      check("rw_buy", 9'(bus.buy), 9'd1);
      reset = 1'b0;
      tick();
      check("rw_buy_drop", 9'(bus.buy), 9'd0);
      check("rw_credit", 9'(bus.credit), 9'd0);
      check("rw_no_refund", 9'(bus.refund_valid), 9'd0);
      check("rw_no_fail", 9'(bus.vend_fail), 9'd0);
      reset = 1'b1;
      refund();
      check("zero_refund_valid", 9'(bus.refund_valid), 9'd1);
      check("zero_refund_amount", 9'(bus.refund_amount), 9'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
